// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction memory loader.
// Imported by the top; the RAM sub-module is parameter-only.
package instr_mem_loader_pkg;

  localparam logic [31:0] HALT_OP = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_OP  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    LOADED  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_mem_loader_ram.sv
// Simple dual-port program RAM: one write port, one registered read port.
// The read register holds its last value when no read is requested.
module instr_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array and read register are deliberately left without a reset so
  // the tools can map them onto block RAM; the top masks rdata until it is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Program memory loaded by the debug unit and read by the fetch stage.
// Tracks the load session, gates fetch until a program is complete, raises halt.
module instr_mem_loader #(
  parameter int                 ADDR_W  = 8,
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  HALT_OP = instr_mem_loader_pkg::HALT_OP,
  parameter logic [DATA_W-1:0]  NOP_OP  = instr_mem_loader_pkg::NOP_OP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_instruction,
  input  logic              is_MemWrite,
  input  logic              is_clear,
  input  logic              is_fetch_en,
  input  logic [31:0]       i_pc,
  output logic [DATA_W-1:0] o_fetch_instr,
  output logic              os_fetch_valid,
  output logic              os_loaded,
  output logic              os_halt,
  output logic              os_addr_err,
  output logic [ADDR_W:0]   o_load_count
);

  import instr_mem_loader_pkg::*;

  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W+1)'(2**ADDR_W);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic              fetch_valid_q;
  logic              halt_q;
  logic              addr_err_q;
  logic [DATA_W-1:0] ram_q;

  logic load_we;
  logic fetch_try;
  logic pc_bad;
  logic fetch_rd;
  logic halt_now;

  // is_clear outranks both the write strobe and the fetch request.
  assign load_we   = is_MemWrite && !is_clear && (state != LOADED);
  assign fetch_try = is_fetch_en && !is_clear && (state == LOADED) && !os_halt;
  assign pc_bad    = (|i_pc[1:0]) || (|i_pc[31:ADDR_W+2]);
  assign fetch_rd  = fetch_try && !pc_bad;

  // Halt must be visible alongside the HALT_OP word itself, before halt_q catches up.
  assign halt_now  = fetch_valid_q && (ram_q == HALT_OP);

  instr_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (load_we),
    .waddr (i_address),
    .wdata (i_instruction),
    .re    (fetch_rd),
    .raddr (i_pc[ADDR_W+1:2]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      fetch_valid_q <= 1'b0;
      halt_q        <= 1'b0;
      addr_err_q    <= 1'b0;
    end else if (is_clear) begin
      state         <= IDLE;
      count         <= '0;
      fetch_valid_q <= 1'b0;
      halt_q        <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_rd;
      if (halt_now)            halt_q     <= 1'b1;
      if (fetch_try && pc_bad) addr_err_q <= 1'b1;
      if (load_we) begin
        if (count != COUNT_MAX) count <= count + 1'b1;
        state <= (i_instruction == HALT_OP) ? LOADED : LOADING;
      end
    end
  end

  assign o_fetch_instr  = fetch_valid_q ? ram_q : NOP_OP;
  assign os_fetch_valid = fetch_valid_q;
  assign os_loaded      = (state == LOADED);
  assign os_halt        = halt_q || halt_now;
  assign os_addr_err    = addr_err_q;
  assign o_load_count   = count;

endmodule
